// File: rtl/fix_framer.sv
// FIX byte-stream framer: hunts for the "8=" header, forwards body bytes with
// start/end strobes, and converts the three-digit "10=" trailer to binary.
module fix_framer #(
  parameter int unsigned MAX_LEN = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       start_o,
  output logic       end_o,
  output logic [7:0] rcv_checksum_o,
  output logic       rcv_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ACC_W  = 10;
  localparam int unsigned DIG_W  = 2;

  localparam logic [BYTE_W-1:0] CH_SOH = 8'h01;
  localparam logic [BYTE_W-1:0] CH_0   = 8'h30;
  localparam logic [BYTE_W-1:0] CH_1   = 8'h31;
  localparam logic [BYTE_W-1:0] CH_8   = 8'h38;
  localparam logic [BYTE_W-1:0] CH_9   = 8'h39;
  localparam logic [BYTE_W-1:0] CH_EQ  = 8'h3D;

  typedef enum logic [2:0] {IDLE, HDR, BODY, T1, T0, DIG, TERM} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [DIG_W-1:0]   dig_q, dig_d;
  logic               soh_q, soh_d;
  logic [BYTE_W-1:0]  data_q, data_d;
  logic               dv_q, dv_d;
  logic               start_q, start_d;
  logic               end_q, end_d;
  logic [BYTE_W-1:0]  rcv_q, rcv_d;
  logic               rv_q, rv_d;
  logic               err_q, err_d;

  logic [CNT_W-1:0]   fwd_cnt;
  logic [ACC_W-1:0]   acc_next;
  logic               is_digit;

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dig_q   <= '0;
      soh_q   <= 1'b0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      rcv_q   <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dig_q   <= dig_d;
      soh_q   <= soh_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      start_q <= start_d;
      end_q   <= end_d;
      rcv_q   <= rcv_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
    end
  end

  // Next-state and output decode; idle input cycles only clear the pulses
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    dig_d    = dig_q;
    soh_d    = soh_q;
    data_d   = data_q;
    dv_d     = 1'b0;
    start_d  = 1'b0;
    end_d    = 1'b0;
    rcv_d    = rcv_q;
    rv_d     = 1'b0;
    err_d    = 1'b0;
    fwd_cnt  = cnt_q + CNT_W'(1);
    acc_next = (acc_q * ACC_W'(10)) + {6'd0, data_i[3:0]};
    is_digit = (data_i >= CH_0) && (data_i <= CH_9);

    if (valid_i) begin
      unique case (state_q)
        IDLE: begin
          if (data_i == CH_8) state_d = HDR;
        end
        HDR: begin
          if (data_i == CH_EQ) begin
            start_d = 1'b1;
            cnt_d   = '0;
            soh_d   = 1'b0;
            state_d = BODY;
          end else if (data_i != CH_8) begin
            state_d = IDLE;
          end
        end
        BODY, T1, T0: begin
          dv_d   = 1'b1;
          data_d = data_i;
          cnt_d  = fwd_cnt;
          soh_d  = (data_i == CH_SOH);
          // A completed trailer tag takes priority over the length abort
          if (state_q == T0 && data_i == CH_EQ) begin
            end_d   = 1'b1;
            acc_d   = '0;
            dig_d   = '0;
            state_d = DIG;
          end else if (fwd_cnt >= CNT_W'(MAX_LEN)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (state_q == BODY) begin
            if (data_i == CH_1 && soh_q) state_d = T1;
          end else if (state_q == T1 && data_i == CH_0) begin
            state_d = T0;
          end else begin
            state_d = BODY;
          end
        end
        DIG: begin
          if (!is_digit) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            acc_d = acc_next;
            dig_d = dig_q + DIG_W'(1);
            if (dig_q == DIG_W'(2)) begin
              if (acc_next > ACC_W'(255)) begin
                err_d   = 1'b1;
                state_d = IDLE;
              end else begin
                state_d = TERM;
              end
            end
          end
        end
        TERM: begin
          if (data_i == CH_SOH) begin
            rcv_d = acc_q[BYTE_W-1:0];
            rv_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign data_o         = data_q;
  assign data_valid_o   = dv_q;
  assign start_o        = start_q;
  assign end_o          = end_q;
  assign rcv_checksum_o = rcv_q;
  assign rcv_valid_o    = rv_q;
  assign frame_err_o    = err_q;

endmodule
